// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - zero-fill sequencer and round-robin write/read arbiters for one register file
// Read data is registered, so every granted read returns one cycle after its grant.
module regfile_access_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_req,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [NUM_REQ*AWIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DWIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_gnt,
    input  logic [NUM_REQ-1:0]        rd_req,
    input  logic [NUM_REQ*AWIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]        rd_gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DWIDTH-1:0]         rd_data,
    output logic                      rf_wr_en,
    output logic [AWIDTH-1:0]         rf_wr_addr,
    output logic [DWIDTH-1:0]         rf_wr_data,
    output logic [AWIDTH-1:0]         rf_rd_addr,
    input  logic [DWIDTH-1:0]         rf_rd_data,
    output logic                      init_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {BOOT, INIT, RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_init_cnt;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [NUM_REQ-1:0]  r_rd_valid;
    logic [DWIDTH-1:0]   r_rd_data;
    logic                r_init_done;
    logic [PW:0]         w_wr_pick;
    logic [PW:0]         w_rd_pick;
    logic                w_wr_any;
    logic                w_rd_any;
    logic [PW-1:0]       w_wr_idx;
    logic [PW-1:0]       w_rd_idx;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Scan downward so the last hit kept is the first requester at or after ptr.
    function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] pick;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) pick = {1'b1, wrap_add(ptr, k)};
        end
        return pick;
    endfunction

    assign w_wr_pick = (r_state == RUN) ? rr_pick(wr_req, r_wr_ptr) : '0;
    assign w_rd_pick = (r_state == RUN) ? rr_pick(rd_req, r_rd_ptr) : '0;
    assign w_wr_any  = w_wr_pick[PW];
    assign w_rd_any  = w_rd_pick[PW];
    assign w_wr_idx  = w_wr_pick[PW-1:0];
    assign w_rd_idx  = w_rd_pick[PW-1:0];

    assign wr_gnt    = w_wr_any ? (NUM_REQ'(1) << w_wr_idx) : '0;
    assign rd_gnt    = w_rd_any ? (NUM_REQ'(1) << w_rd_idx) : '0;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign init_done = r_init_done;

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        rf_rd_addr = '0;
        if (r_state == INIT) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = r_init_cnt;
        end else if (w_wr_any) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = wr_addr[int'(w_wr_idx)*AWIDTH +: AWIDTH];
            rf_wr_data = wr_data[int'(w_wr_idx)*DWIDTH +: DWIDTH];
        end
        if (w_rd_any) rf_rd_addr = rd_addr[int'(w_rd_idx)*AWIDTH +: AWIDTH];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = INIT;
            INIT:    if (r_init_cnt == LAST_ADDR) w_state_nxt = RUN;
            RUN:     if (clr_req) w_state_nxt = INIT;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BOOT;
            r_init_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_valid  <= '0;
            r_rd_data   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == RUN);
            r_rd_valid  <= rd_gnt;
            // Counter wraps back to zero on its own as INIT finishes.
            if (r_state == INIT) r_init_cnt <= r_init_cnt + 1'b1;
            if (w_wr_any) r_wr_ptr <= wrap_add(w_wr_idx, 1);
            if (w_rd_any) begin
                r_rd_ptr  <= wrap_add(w_rd_idx, 1);
                r_rd_data <= rf_rd_data;
            end
        end
    end

endmodule
